darkroom_spi_receiver: RTL and testbench
========================================

DARKROOM_SPI_RECEIVER -- requirements
Module: darkroom_spi_receiver

Interface
REQ-001 Parameter WORD_WIDTH, default 32, meaning: data bits per SPI word, MSB first.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning: received-word buffer entries, power of two, at least 2.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sck_i  input  1  SPI clock from the tracker master (mode 0), asynchronous to clk.
REQ-006 mosi_i  input  1  SPI data from master, asynchronous to clk.
REQ-007 ss_n_i  input  1  SPI select, active-low, asynchronous to clk.
REQ-008 word_o  output  WORD_WIDTH  head-of-FIFO word.
REQ-009 valid_o  output  1  word_o holds an unread word.
REQ-010 ready_i  input  1  consumer accepts word_o when valid_o and ready_i are both high.
REQ-011 overflow_o  output  1  sticky: a completed word was dropped because the FIFO was full.
REQ-012 frame_err_o  output  1  one-cycle pulse: a frame ended mid-word.
REQ-013 parity_err_o  output  1  one-cycle pulse on a parity mismatch (REQ-031 only).

Function
REQ-014 Synchronise sck_i, mosi_i and ss_n_i through two flops each; all decoding uses the synchronised copies.
REQ-015 Require the clk frequency to be at least 4x the sck frequency; below that, behaviour is undefined.
REQ-016 Sample mosi on each synchronised sck rising edge while synchronised ss_n is low; shift MSB first.
REQ-017 Use states IDLE (ss_n high), SHIFT (ss_n low, collecting bits) and PUSH (word complete, single cycle).
REQ-018 IDLE -> SHIFT on the ss_n falling edge; clear the bit counter and shift register.
REQ-019 SHIFT -> PUSH on the sck rise that completes the word; PUSH -> SHIFT on the next cycle with the bit counter at 0, so back-to-back words need no ss_n toggle.
REQ-020 On the ss_n rising edge, enter IDLE from any state; if the bit counter is nonzero, discard the partial word and pulse frame_err_o.
REQ-021 Ignore sck edges while ss_n is high.
REQ-022 In PUSH, write the word to the FIFO if it is not full, or if it is full and a pop occurs in the same cycle.
REQ-023 If the FIFO is full with no pop in the PUSH cycle, drop the word and set overflow_o; FIFO contents stay unchanged.
REQ-024 Keep overflow_o high until reset.
REQ-025 Raise valid_o on the clk edge after the PUSH cycle: 1 cycle of PUSH-to-valid latency, and 4 cycles from the synchronised sck edge at the pin.
REQ-026 On a pop, advance word_o to the next entry in the same edge; drop valid_o when the FIFO becomes empty.
REQ-027 Wrap FIFO pointers modulo FIFO_DEPTH; hold occupancy in log2(FIFO_DEPTH)+1 bits.
REQ-028 Ignore ready_i while valid_o is low; leave FIFO state unchanged.

Reset
REQ-029 While rst is high: state IDLE, counters, pointers and shift register 0, word_o 0, valid_o 0, overflow_o 0, frame_err_o 0, parity_err_o 0.
REQ-030 Discard any in-flight word and all buffered words on reset; after rst falls, start the first frame only at the next ss_n falling edge seen low-after-high.

Configuration
REQ-031 Macro DARKROOM_SPI_RX_PARITY_EN defined:
  - each word is WORD_WIDTH+1 bits, the last bit being even parity over the data bits;
  - on a mismatch, drop the word and pulse parity_err_o in the PUSH cycle;
  - otherwise the word is pushed normally.
REQ-032 Macro undefined: words are WORD_WIDTH bits; no parity logic; parity_err_o tied 0.

Verification
REQ-033 ss_n low, 32 bits 0xA5C3_0F01, ss_n high, ready_i=1 -> word_o=0xA5C30F01, valid_o high for 1 cycle, 4 cycles after the last sck rise; no error pulses.
REQ-034 One frame of 3 back-to-back words 0x1, 0x2, 0x3, ready_i=0 -> valid_o stays high; with ready_i later 1, pops return 0x1, 0x2, 0x3 in order, then valid_o=0.
REQ-035 FIFO_DEPTH=4, ready_i=0, 5 words -> first 4 retained, overflow_o=1 after the 5th PUSH; then 4 pops give words 1-4.
REQ-036 FIFO full, 5th word PUSH in the same cycle as a pop -> no overflow; entries 2-5 readable.
REQ-037 ss_n rises after 17 bits -> frame_err_o pulses once, nothing pushed; the next full word is received correctly.
REQ-038 Parity enabled, 0x00000001 sent with parity bit 0 -> parity_err_o pulse, valid_o stays 0; rst asserted mid-word -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/darkroom_spi_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// darkroom_spi_receiver : SPI mode-0 slave receiver with word FIFO
// Optional feature macro: DARKROOM_SPI_RX_PARITY_EN (trailing even-parity bit)
// Revision: 1.0
// ============================================================================
module darkroom_spi_receiver #(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck_i,
  input  logic                  mosi_i,
  input  logic                  ss_n_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overflow_o,
  output logic                  frame_err_o,
  output logic                  parity_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef DARKROOM_SPI_RX_PARITY_EN
  localparam int FRAME_BITS = WORD_WIDTH + 1;
`else
  localparam int FRAME_BITS = WORD_WIDTH;
`endif
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PUSH  = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_mosi_s1, r_mosi_s2;
  logic r_ss_s1, r_ss_s2, r_ss_d;

  logic [BIT_W-1:0]      r_bit_cnt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_frame_err;
  logic                  r_overflow;

  logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_sck_rise, w_ss_fall, w_ss_rise;
  logic w_parity_ok, w_push_req, w_full, w_pop, w_push;

  // Select flops reset low so a select already low at reset release is not
  // mistaken for a falling edge; a frame needs a fresh high-to-low transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_ss_d    <= 1'b0;
    end else begin
      r_sck_s1  <= sck_i;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_mosi_s1 <= mosi_i;
      r_mosi_s2 <= r_mosi_s1;
      r_ss_s1   <= ss_n_i;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_d & ~r_ss_s2;
  assign w_ss_fall  = ~r_ss_s2 & r_ss_d;
  assign w_ss_rise  = r_ss_s2 & ~r_ss_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ss_fall) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_ss_rise)                                  w_next = S_IDLE;
        else if (w_sck_rise && r_bit_cnt == C_LAST_BIT) w_next = S_PUSH;
      end
      S_PUSH:  w_next = w_ss_rise ? S_IDLE : S_SHIFT;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef DARKROOM_SPI_RX_PARITY_EN
  logic r_par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else if (r_state == S_IDLE && w_ss_fall) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (w_ss_rise) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise) begin
        if (r_bit_cnt == C_LAST_BIT) begin
          r_bit_cnt <= '0;
          r_par_bit <= r_mosi_s2;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_shift   <= {r_shift[WORD_WIDTH-2:0], r_mosi_s2};
        end
      end
    end
  end

  assign w_parity_ok  = ((^r_shift) == r_par_bit);
  assign parity_err_o = (r_state == S_PUSH) & ~w_parity_ok;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_state == S_IDLE && w_ss_fall) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_state == S_SHIFT) begin
      if (w_ss_rise) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise) begin
        r_bit_cnt <= (r_bit_cnt == C_LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
        r_shift   <= {r_shift[WORD_WIDTH-2:0], r_mosi_s2};
      end
    end
  end

  assign w_parity_ok  = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= (r_state == S_SHIFT) && w_ss_rise && (r_bit_cnt != '0);
  end

  assign frame_err_o = r_frame_err;

  // A full FIFO still accepts the word when the head is popped in the same edge.
  assign w_push_req = (r_state == S_PUSH) & w_parity_ok;
  assign w_full     = (r_count == C_FULL);
  assign valid_o    = (r_count != '0);
  assign w_pop      = valid_o & ready_i;
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
  assign word_o     = valid_o ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_darkroom_spi_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_darkroom_spi_receiver : directed self-checking bench for the SPI receiver
// Revision: 1.0
// ============================================================================
module tb_darkroom_spi_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck_i, mosi_i, ss_n_i, ready_i;
  logic [31:0] word_o;
  logic        valid_o, overflow_o, frame_err_o, parity_err_o;

  int  checks = 0;
  int  errors = 0;
  int  n_ferr = 0;
  int  n_perr = 0;
  int  base_ferr;
  int  base_perr;
  time t_sck = 0;
  time t_valid = 0;
  logic v_prev = 1'b0;

  darkroom_spi_receiver #(.WORD_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sck_i        (sck_i),
    .mosi_i       (mosi_i),
    .ss_n_i       (ss_n_i),
    .word_o       (word_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .overflow_o   (overflow_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge sck_i) t_sck = $time;

  always @(negedge clk) begin
    if (frame_err_o)  n_ferr++;
    if (parity_err_o) n_perr++;
    if (valid_o && !v_prev) t_valid = $time;
    v_prev = valid_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      #10 mosi_i = d[i];
      #30 sck_i  = 1'b1;
      #40 sck_i  = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
`ifdef DARKROOM_SPI_RX_PARITY_EN
    send_bits({31'b0, w, ^w}, 33);
`else
    send_bits({32'b0, w}, 32);
`endif
  endtask

  task automatic send_head(input logic [31:0] w);
`ifdef DARKROOM_SPI_RX_PARITY_EN
    send_bits({32'b0, w}, 32);
`else
    send_bits({33'b0, w[31:1]}, 31);
`endif
  endtask

  function automatic logic last_bit(input logic [31:0] w);
`ifdef DARKROOM_SPI_RX_PARITY_EN
    return ^w;
`else
    return w[0];
`endif
  endfunction

  task automatic frame_start;
    ss_n_i = 1'b0;
    #40;
  endtask

  task automatic frame_end;
    #40 ss_n_i = 1'b1;
    #100;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    ready_i = 1'b1;
    #1;
    check({tag, "_valid"}, 64'(valid_o), 64'd1);
    check({tag, "_word"}, 64'(word_o), 64'(exp));
    #9 ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sck_i = 1'b0; mosi_i = 1'b0; ss_n_i = 1'b1; ready_i = 1'b0;
    #1;
    check("rst_word",  64'(word_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ovf",   64'(overflow_o), 64'd0);
    check("rst_ferr",  64'(frame_err_o), 64'd0);
    check("rst_perr",  64'(parity_err_o), 64'd0);
    #29 rst = 1'b0;
    #50;

    // Single word, consumer always ready: valid for exactly one cycle.
    ready_i = 1'b1;
    base_ferr = n_ferr;
    frame_start;
    send_word(32'hA5C3_0F01);
    #1;
    check("w1_valid",   64'(valid_o), 64'd1);
    check("w1_word",    64'(word_o), 64'hA5C3_0F01);
    check("w1_latency", 64'(t_valid - t_sck), 64'd40);
    #10;
    check("w1_valid_drop", 64'(valid_o), 64'd0);
    #9;
    ready_i = 1'b0;
    frame_end;
    check("w1_no_ferr", 64'(n_ferr - base_ferr), 64'd0);
    check("w1_no_perr", 64'(n_perr), 64'd0);

    // Three back-to-back words in one frame, popped later.
    frame_start;
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    frame_end;
    #200;
    check("b2b_hold_valid", 64'(valid_o), 64'd1);
    pop_check("b2b_pop1", 32'h1);
    pop_check("b2b_pop2", 32'h2);
    pop_check("b2b_pop3", 32'h3);
    #1 check("b2b_empty", 64'(valid_o), 64'd0);
    #9;

    // Overflow: four fit, fifth dropped.
    frame_start;
    send_word(32'h11); send_word(32'h12); send_word(32'h13); send_word(32'h14);
    frame_end;
    check("ovf_before", 64'(overflow_o), 64'd0);
    frame_start;
    send_word(32'h15);
    frame_end;
    check("ovf_set", 64'(overflow_o), 64'd1);
    pop_check("ovf_pop1", 32'h11);
    pop_check("ovf_pop2", 32'h12);
    pop_check("ovf_pop3", 32'h13);
    pop_check("ovf_pop4", 32'h14);
    #1 check("ovf_empty", 64'(valid_o), 64'd0);
    check("ovf_sticky", 64'(overflow_o), 64'd1);
    #9 rst = 1'b1;
    #10 rst = 1'b0;
    #1 check("ovf_cleared", 64'(overflow_o), 64'd0);
    #49;

    // Full FIFO, fifth word pushed in the same edge as a pop.
    frame_start;
    send_word(32'h21); send_word(32'h22); send_word(32'h23); send_word(32'h24);
    send_head(32'h25);
    #10 mosi_i = last_bit(32'h25);
    #30 sck_i  = 1'b1;
    #30 ready_i = 1'b1;
    #10 ready_i = 1'b0; sck_i = 1'b0;
    frame_end;
    check("pp_no_ovf", 64'(overflow_o), 64'd0);
    pop_check("pp_pop2", 32'h22);
    pop_check("pp_pop3", 32'h23);
    pop_check("pp_pop4", 32'h24);
    pop_check("pp_pop5", 32'h25);
    #1 check("pp_empty", 64'(valid_o), 64'd0);
    #9;

    // Frame ending after 17 bits, then a clean word.
    base_ferr = n_ferr;
    frame_start;
    send_bits(64'h1ABCD, 17);
    frame_end;
    check("fe_pulse", 64'(n_ferr - base_ferr), 64'd1);
    check("fe_nopush", 64'(valid_o), 64'd0);
    frame_start;
    send_word(32'h5A5A_F00F);
    frame_end;
    check("fe_next_ferr", 64'(n_ferr - base_ferr), 64'd1);
    pop_check("fe_next", 32'h5A5A_F00F);
    #1 check("fe_empty", 64'(valid_o), 64'd0);
    #9;

`ifdef DARKROOM_SPI_RX_PARITY_EN
    base_perr = n_perr;
    frame_start;
    send_bits({31'b0, 32'h1, 1'b0}, 33);
    frame_end;
    check("par_pulse", 64'(n_perr - base_perr), 64'd1);
    check("par_drop", 64'(valid_o), 64'd0);
`else
    base_perr = n_perr;
    check("par_tied", 64'(n_perr - base_perr) + 64'(parity_err_o), 64'd0);
`endif

    // Reset mid-word with a buffered word present.
    frame_start;
    send_word(32'h600D_CAFE);
    frame_end;
    check("mid_pre_valid", 64'(valid_o), 64'd1);
    frame_start;
    send_bits(64'h2AA, 10);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_word",  64'(word_o), 64'd0);
    check("mid_rst_ovf",   64'(overflow_o), 64'd0);
    check("mid_rst_ferr",  64'(frame_err_o), 64'd0);
    check("mid_rst_perr",  64'(parity_err_o), 64'd0);
    #6;
    #20 rst = 1'b0;
    base_ferr = n_ferr;
    send_word(32'hFFFF_FFFF);
    frame_end;
    check("post_rst_nopush", 64'(valid_o), 64'd0);
    check("post_rst_noferr", 64'(n_ferr - base_ferr), 64'd0);
    frame_start;
    send_word(32'h0BAD_F00D);
    frame_end;
    pop_check("post_rst_word", 32'h0BAD_F00D);
    #1 check("post_rst_empty", 64'(valid_o), 64'd0);
    #9;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
